// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the processor, DMA and data-memory signals around
// the data-memory arbiter.
//   slave  : arbiter side (takes requests, drives grants and memory controls)
//   master : environment side (processor core, DMA engine, data memory)
interface dmem_arbiter_if #(
   parameter int ADDSIZE = 6
);
   logic               cpu_req;
   logic               cpu_we;
   logic [ADDSIZE-1:0] cpu_addr;
   logic [31:0]        cpu_wdata;
   logic [31:0]        cpu_rdata;
   logic               cpu_stall;

   logic               dma_req;
   logic               dma_we;
   logic [ADDSIZE-1:0] dma_addr;
   logic [31:0]        dma_wdata;
   logic               dma_ack;
   logic [31:0]        dma_rdata;
   logic               dma_rvalid;

   logic [ADDSIZE-1:0] mem_addr;
   logic [31:0]        mem_wdata;
   logic               mem_read;
   logic               mem_write;
   logic [31:0]        mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ack, dma_rdata, dma_rvalid,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ack, dma_rdata, dma_rvalid,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the processor
// load/store path and a word-wide DMA port. The processor has priority; after
// MAXWAIT consecutive denied DMA cycles the DMA is granted once and the
// processor stalls for that cycle.
// Ports:
//   CLK, Reset : clock (rising edge), asynchronous active-high reset
//   bus        : processor / DMA / memory signals (slave modport)
//   force_cnt  : saturating count of forced grants that stalled the processor
module dmem_arbiter #(
   parameter int ADDSIZE = 6,
   parameter int MAXWAIT = 4   // legal 1..15
) (
   input  logic        CLK,
   input  logic        Reset,
   dmem_arbiter_if.slave bus,
   output logic [15:0] force_cnt
);
   typedef enum logic {NORMAL, FORCE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

   localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

   state_t     state, state_nxt;
   owner_t     owner;
   logic [3:0] wait_cnt, wait_nxt;

   // Ownership: FORCE hands the DMA priority for exactly one granted cycle.
   always_comb begin
      owner = OWN_NONE;
      if (state == FORCE && bus.dma_req) owner = OWN_DMA;
      else if (bus.cpu_req)              owner = OWN_CPU;
      else if (bus.dma_req)              owner = OWN_DMA;
   end

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      case (owner)
         OWN_CPU: begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_read  = !bus.cpu_we;
            bus.mem_write = bus.cpu_we & !Reset;  // no write while in reset
         end
         OWN_DMA: begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_read  = !bus.dma_we;
            bus.mem_write = bus.dma_we & !Reset;
         end
         default: ;
      endcase
   end

   assign bus.dma_ack   = (owner == OWN_DMA);
   assign bus.cpu_stall = bus.cpu_req & (owner == OWN_DMA);
   assign bus.cpu_rdata = (owner == OWN_CPU) ? bus.mem_rdata : 32'h0;

   // Next-state logic: the wait counter only runs while the DMA is being denied.
   always_comb begin
      wait_nxt  = wait_cnt;
      state_nxt = state;
      if (!bus.dma_req || owner == OWN_DMA) wait_nxt = 4'd0;
      else if (wait_cnt != WAIT_MAX)        wait_nxt = wait_cnt + 4'd1;
      case (state)
         NORMAL: if (wait_nxt == WAIT_MAX) state_nxt = FORCE;
         FORCE:  if (bus.dma_ack || !bus.dma_req) state_nxt = NORMAL;
         default: state_nxt = NORMAL;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state          <= NORMAL;
         wait_cnt       <= 4'd0;
         force_cnt      <= 16'd0;
         bus.dma_rdata  <= 32'h0;
         bus.dma_rvalid <= 1'b0;
      end else begin
         state          <= state_nxt;
         wait_cnt       <= wait_nxt;
         // only grants that actually displaced a processor access count
         if (state == FORCE && bus.dma_ack && bus.cpu_req && force_cnt != 16'hFFFF)
            force_cnt <= force_cnt + 16'd1;
         bus.dma_rvalid <= bus.dma_ack & !bus.dma_we;
         if (bus.dma_ack && !bus.dma_we)
            bus.dma_rdata <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
   logic        CLK = 1'b0;
   logic        Reset;
   logic [15:0] force_cnt;
   int          checks = 0;
   int          errors = 0;

   dmem_arbiter_if #(.ADDSIZE(6)) bus();

   dmem_arbiter #(.ADDSIZE(6), .MAXWAIT(4)) dut (
      .CLK(CLK), .Reset(Reset), .bus(bus), .force_cnt(force_cnt)
   );

   always #5 CLK = ~CLK;

   // data memory model: combinational read, write on the clock edge
   logic [31:0] tb_mem [64];
   assign bus.mem_rdata = tb_mem[bus.mem_addr];
   always @(posedge CLK) if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_wdata;

   typedef struct {
      logic        cr, cw; logic [5:0] ca; logic [31:0] cd;
      logic        dr, dw; logic [5:0] da; logic [31:0] dd;
      logic        e_ack, e_stall, e_mw, e_mr; logic [5:0] e_ma;
      logic [31:0] e_crd; bit chk_crd; logic [31:0] e_drd; logic [15:0] e_fc;
   } vec_t;

   vec_t        tbl [$];
   logic [31:0] sb  [$];   // expected DMA read data, in order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic cr, cw, input logic [5:0] ca, input logic [31:0] cd,
                               input logic dr, dw, input logic [5:0] da, input logic [31:0] dd,
                               input logic ack, stall, mw, mr, input logic [5:0] ma,
                               input logic [31:0] crd, input bit chk, input logic [31:0] drd,
                               input logic [15:0] fc);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
      v.e_ack = ack; v.e_stall = stall; v.e_mw = mw; v.e_mr = mr; v.e_ma = ma;
      v.e_crd = crd; v.chk_crd = chk; v.e_drd = drd; v.e_fc = fc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.cpu_req = v.cr; bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
      bus.dma_req = v.dr; bus.dma_we = v.dw; bus.dma_addr = v.da; bus.dma_wdata = v.dd;
   endtask

   // read-data monitor: one cycle after each expected DMA read ack
   always @(posedge CLK) begin
      #2;
      if (Reset) begin
         sb.delete();
         chk("rvalid_in_reset", {31'b0, bus.dma_rvalid}, 32'd0);
      end else if (sb.size() > 0) begin
         logic [31:0] e;
         e = sb.pop_front();
         chk("dma_rvalid", {31'b0, bus.dma_rvalid}, 32'd1);
         chk("dma_rdata", bus.dma_rdata, e);
      end else begin
         chk("dma_rvalid_idle", {31'b0, bus.dma_rvalid}, 32'd0);
      end
   end

   initial begin
      vec_t v;
      // reset with every request high
      Reset = 1'b1;
      drive(mk(1,1,6'd7,32'h1111_1111, 1,1,6'd9,32'h2222_2222, 0,0,0,0,0, 0,0,0,0));
      @(posedge CLK); #4;
      chk("rst mem_write", {31'b0, bus.mem_write}, 32'd0);
      chk("rst dma_ack",   {31'b0, bus.dma_ack},   32'd0);
      chk("rst cpu_stall", {31'b0, bus.cpu_stall}, 32'd0);
      chk("rst force_cnt", {16'b0, force_cnt},     32'd0);
      chk("rst dma_rvalid",{31'b0, bus.dma_rvalid},32'd0);
      @(posedge CLK); #1;
      Reset = 1'b0;
      drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0));

      // basic CPU and DMA-only traffic
      tbl.push_back(mk(1,1,6'd5,32'h1234_5678, 0,0,0,0, 0,0,1,0,6'd5, 0,0,0,0));
      tbl.push_back(mk(1,0,6'd5,0, 0,0,0,0, 0,0,0,1,6'd5, 32'h1234_5678,1,0,0));
      tbl.push_back(mk(0,0,0,0, 1,1,6'd10,32'hDEAD_BEEF, 1,0,1,0,6'd10, 0,1,0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,6'd0, 0,1,0,0));
      tbl.push_back(mk(0,0,0,0, 1,0,6'd10,0, 1,0,0,1,6'd10, 0,1,32'hDEAD_BEEF,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,6'd0, 0,1,0,0));
      // 20 cycles of contention: grants at 4, 9, 14, 19
      for (int i = 0; i < 20; i++) begin
         logic a;
         logic [5:0] da;
         a  = (i % 5 == 4);
         da = 6'(32 + i / 5);
         tbl.push_back(mk(1,0,6'(i),0, 1,1,da,32'(i), a,a,a,!a, a ? da : 6'(i),
                          0,a,0,16'(i / 5)));
      end
      // withdrawal at w2, re-raise at w3, forced read granted at w7
      for (int i = 0; i < 8; i++) begin
         logic dr, a;
         dr = (i != 2);
         a  = (i == 7);
         tbl.push_back(mk(1,0,6'(i),0, dr,0,6'd10,0, a,a,0,1, a ? 6'd10 : 6'(i),
                          0,a,32'hDEAD_BEEF,16'd4));
      end
      tbl.push_back(mk(1,0,6'd5,0, 0,0,0,0, 0,0,0,1,6'd5, 32'h1234_5678,1,0,16'd5));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(posedge CLK); #1;
         drive(v);
         #3;
         chk($sformatf("v%0d dma_ack", i),   {31'b0, bus.dma_ack},   {31'b0, v.e_ack});
         chk($sformatf("v%0d cpu_stall", i), {31'b0, bus.cpu_stall}, {31'b0, v.e_stall});
         chk($sformatf("v%0d mem_write", i), {31'b0, bus.mem_write}, {31'b0, v.e_mw});
         chk($sformatf("v%0d mem_read", i),  {31'b0, bus.mem_read},  {31'b0, v.e_mr});
         chk($sformatf("v%0d mem_addr", i),  {26'b0, bus.mem_addr},  {26'b0, v.e_ma});
         chk($sformatf("v%0d force_cnt", i), {16'b0, force_cnt},     {16'b0, v.e_fc});
         if (v.chk_crd)
            chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, v.e_crd);
         if (v.e_ack && !v.dw) sb.push_back(v.e_drd);
      end

      // reset in the cycle after a DMA read ack
      @(posedge CLK); #1;
      drive(mk(0,0,0,0, 1,0,6'd10,0, 0,0,0,0,0, 0,0,0,0));
      #3;
      chk("mid dma_ack", {31'b0, bus.dma_ack}, 32'd1);
      @(posedge CLK); #1;
      Reset = 1'b1;
      drive(mk(1,1,6'd3,32'hFFFF_0000, 1,1,6'd4,32'h0F0F_0F0F, 0,0,0,0,0, 0,0,0,0));
      #3;
      chk("mid mem_write", {31'b0, bus.mem_write}, 32'd0);
      chk("mid dma_rdata", bus.dma_rdata, 32'd0);
      chk("mid force_cnt", {16'b0, force_cnt}, 32'd0);
      chk("mid cpu_stall", {31'b0, bus.cpu_stall}, 32'd0);
      @(posedge CLK); #1;
      Reset = 1'b0;
      drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0));
      repeat (2) @(posedge CLK);
      #4;
      chk("post dma_rdata", bus.dma_rdata, 32'd0);
      chk("sb drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
